// File: rtl/pc_sequencer_if.sv
// Branch-resolve / fetch-PC bundle between execute, fetch and pc_sequencer.
// The master side is execute/fetch; the slave side is the sequencer.
interface pc_sequencer_if #(
   parameter int WordSize = 32
);
   logic                stall;
   logic                br_valid;
   logic                br_taken;
   logic [WordSize-1:0] br_target;
   logic                br_ready;
   logic [WordSize-1:0] pc;
   logic                fetch_valid;
   logic                flush;
   logic                br_misalign;

   modport master (
      output stall, br_valid, br_taken, br_target,
      input  br_ready, pc, fetch_valid, flush, br_misalign
   );

   modport slave (
      input  stall, br_valid, br_taken, br_target,
      output br_ready, pc, fetch_valid, flush, br_misalign
   );
endinterface

// File: rtl/pc_sequencer.sv
// Fetch PC sequencer: sequential fetch, taken-branch redirect, fixed-length flush.
// Optional build macro MISALIGN_TRAP_EN redirects misaligned taken targets to TrapVector.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_BOOT  | one cycle after reset, pc = ResetVector, no fetch
// ST_RUN   | fetching at pc, branches accepted, pc advances unless stalled
// ST_FLUSH | redirect in progress, flush asserted, pc holds the target
module pc_sequencer #(
   parameter int                  WordSize    = 32,
   parameter logic [WordSize-1:0] ResetVector = '0,
   parameter int                  FlushCycles = 2,
   parameter logic [WordSize-1:0] TrapVector  = WordSize'(32'h0000_0100)
) (
   input logic            clk,
   input logic            rst,
   pc_sequencer_if.slave  bus
);

   typedef enum logic [1:0] {
      ST_BOOT  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLUSH = 2'd2
   } state_t;

   localparam logic [3:0]          FlushInit = 4'(FlushCycles - 1);
   localparam logic [WordSize-1:0] PcStep    = WordSize'(4);
   localparam logic [WordSize-1:0] AlignMask = ~WordSize'(3);

   state_t              state_q, state_d;
   logic [WordSize-1:0] pc_q, pc_d;
   logic [3:0]          cnt_q, cnt_d;
   logic                take_branch;

`ifdef MISALIGN_TRAP_EN
   logic                mis_q, mis_d;
`endif

   // A branch only counts while ready, i.e. in RUN; anything else is dropped.
   assign take_branch = bus.br_valid && bus.br_taken && (state_q == ST_RUN);

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      cnt_d   = cnt_q;
`ifdef MISALIGN_TRAP_EN
      mis_d   = 1'b0;
`endif
      case (state_q)
         ST_BOOT: begin
            state_d = ST_RUN;
         end
         ST_RUN: begin
            if (take_branch) begin
               state_d = ST_FLUSH;
               cnt_d   = FlushInit;
`ifdef MISALIGN_TRAP_EN
               if (|bus.br_target[1:0]) begin
                  pc_d  = TrapVector;
                  mis_d = 1'b1;
               end else begin
                  pc_d  = bus.br_target;
               end
`else
               pc_d    = bus.br_target & AlignMask;
`endif
            end else if (!bus.stall) begin
               pc_d = pc_q + PcStep;
            end
         end
         ST_FLUSH: begin
            if (cnt_q == 4'd0) begin
               state_d = ST_RUN;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: begin
            state_d = ST_BOOT;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_BOOT;
         pc_q    <= ResetVector;
         cnt_q   <= 4'd0;
`ifdef MISALIGN_TRAP_EN
         mis_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         cnt_q   <= cnt_d;
`ifdef MISALIGN_TRAP_EN
         mis_q   <= mis_d;
`endif
      end
   end

   assign bus.pc          = pc_q;
   assign bus.fetch_valid = (state_q == ST_RUN);
   assign bus.br_ready    = (state_q == ST_RUN);
   assign bus.flush       = (state_q == ST_FLUSH);

`ifdef MISALIGN_TRAP_EN
   // Set only on the edge entering FLUSH, so it covers the first flush cycle.
   assign bus.br_misalign = mis_q;
`else
   assign bus.br_misalign = 1'b0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: stimulus pushes expected outputs, a monitor pops and checks.
module tb_pc_sequencer;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   pc_sequencer_if #(.WordSize(32)) bus ();

   pc_sequencer #(
      .WordSize   (32),
      .ResetVector(32'h0000_0000),
      .FlushCycles(2),
      .TrapVector (32'h0000_0100)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

`ifdef MISALIGN_TRAP_EN
   localparam logic [31:0] MIS_PC   = 32'h0000_0100;
   localparam logic        MIS_FLAG = 1'b1;
`else
   localparam logic [31:0] MIS_PC   = 32'h0000_0200;
   localparam logic        MIS_FLAG = 1'b0;
`endif

   typedef struct {
      int          cyc;
      logic [31:0] pc;
      logic        fv;
      logic        fl;
      logic        rdy;
      logic        mis;
   } exp_t;

   exp_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc     = 0;

   task automatic chk(input string name, input int c, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s cycle %0d: got 0x%08h expected 0x%08h", name, c, act, req);
      end
   endtask

   // Drive one cycle's inputs and record what the outputs must be during that cycle.
   task automatic step(input logic r, input logic st, input logic bv, input logic bt,
                       input logic [31:0] tgt, input logic [31:0] epc, input logic efv,
                       input logic efl, input logic erdy, input logic emis, input logic do_chk);
      exp_t e;
      @(posedge clk);
      #1;
      cyc++;
      rst          = r;
      bus.stall    = st;
      bus.br_valid = bv;
      bus.br_taken = bt;
      bus.br_target = tgt;
      if (do_chk) begin
         e.cyc = cyc; e.pc = epc; e.fv = efv; e.fl = efl; e.rdy = erdy; e.mis = emis;
         exp_q.push_back(e);
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("pc",          e.cyc, bus.pc,                 e.pc);
            chk("fetch_valid", e.cyc, 32'(bus.fetch_valid),   32'(e.fv));
            chk("flush",       e.cyc, 32'(bus.flush),         32'(e.fl));
            chk("br_ready",    e.cyc, 32'(bus.br_ready),      32'(e.rdy));
            chk("br_misalign", e.cyc, 32'(bus.br_misalign),   32'(e.mis));
         end
      end
   end

   initial begin : stimulus
      bus.stall = 1'b0; bus.br_valid = 1'b0; bus.br_taken = 1'b0; bus.br_target = '0;
      //    rst st bv bt target          | pc            fv fl rdy mis chk
      step(1, 0, 0, 0, 32'h0,            32'h0,         0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 32'h0,            32'h0,         0, 0, 0, 0, 1); // BOOT
      step(0, 0, 0, 0, 32'h0,            32'h0,         1, 0, 1, 0, 1);
      step(0, 0, 0, 0, 32'h0,            32'h4,         1, 0, 1, 0, 1);
      step(0, 0, 0, 0, 32'h0,            32'h8,         1, 0, 1, 0, 1);
      step(0, 0, 0, 0, 32'h0,            32'hC,         1, 0, 1, 0, 1);
      step(0, 0, 1, 1, 32'h200,          32'h10,        1, 0, 1, 0, 1);
      step(0, 0, 0, 0, 32'h0,            32'h200,       0, 1, 0, 0, 1);
      step(0, 0, 0, 0, 32'h0,            32'h200,       0, 1, 0, 0, 1);
      step(0, 0, 0, 0, 32'h0,            32'h200,       1, 0, 1, 0, 1);
      step(0, 0, 1, 1, 32'h40,           32'h204,       1, 0, 1, 0, 1);
      step(0, 0, 0, 0, 32'h0,            32'h40,        0, 1, 0, 0, 1);
      step(0, 0, 0, 0, 32'h0,            32'h40,        0, 1, 0, 0, 1);
      step(0, 0, 1, 0, 32'h999,          32'h40,        1, 0, 1, 0, 1); // not-taken, advance
      step(0, 1, 1, 0, 32'h999,          32'h44,        1, 0, 1, 0, 1); // not-taken, stalled
      step(0, 1, 1, 1, 32'h300,          32'h44,        1, 0, 1, 0, 1); // redirect beats stall
      step(0, 1, 1, 1, 32'h500,          32'h300,       0, 1, 0, 0, 1); // ignored during flush
      step(0, 1, 1, 1, 32'h500,          32'h300,       0, 1, 0, 0, 1);
      step(0, 1, 0, 0, 32'h0,            32'h300,       1, 0, 1, 0, 1); // first RUN, stalled
      step(0, 0, 0, 0, 32'h0,            32'h300,       1, 0, 1, 0, 1);
      step(0, 0, 1, 1, 32'hFFFF_FFF8,    32'h304,       1, 0, 1, 0, 1);
      step(0, 0, 0, 0, 32'h0,            32'hFFFF_FFF8, 0, 1, 0, 0, 1);
      step(0, 0, 0, 0, 32'h0,            32'hFFFF_FFF8, 0, 1, 0, 0, 1);
      step(0, 0, 0, 0, 32'h0,            32'hFFFF_FFF8, 1, 0, 1, 0, 1);
      step(0, 0, 0, 0, 32'h0,            32'hFFFF_FFFC, 1, 0, 1, 0, 1);
      step(0, 0, 1, 1, 32'h202,          32'h0,         1, 0, 1, 0, 1); // wrapped; misaligned target
      step(0, 0, 0, 0, 32'h0,            MIS_PC,        0, 1, 0, MIS_FLAG, 1);
      step(1, 0, 0, 0, 32'h0,            MIS_PC,        0, 1, 0, 0, 1); // reset mid-flush
      step(0, 0, 0, 0, 32'h0,            32'h0,         0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 32'h0,            32'h0,         1, 0, 1, 0, 1);
      step(0, 0, 0, 0, 32'h0,            32'h4,         1, 0, 1, 0, 1);
      repeat (3) @(negedge clk);
      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
